wb_dbg_master: RTL and testbench

WB_DBG_MASTER -- requirements
Module: wb_dbg_master

---
 rtl/wb_dbg_master.sv | 197 +++++++++++++++++++
 tb/tb_wb_dbg_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dbg_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_dbg_master
// Brief    : Byte-stream command decoder that issues single Wishbone classic
//            read/write cycles and returns an ACK/NAK or read-data response.
// Revision : 1.0
// ============================================================================
module wb_dbg_master #(
    parameter int unsigned bus_timeout = 1024,
    parameter int unsigned rx_timeout  = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic [7:0]  tx_data,
    output logic        tx_stb,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        busy_o
);

    localparam logic [7:0]  c_cmd_write = 8'h01;
    localparam logic [7:0]  c_cmd_read  = 8'h02;
    localparam logic [7:0]  c_rsp_ack   = 8'h06;
    localparam logic [7:0]  c_rsp_nak   = 8'h15;
    localparam logic [15:0] c_bus_last  = 16'(bus_timeout - 1);
    localparam logic [23:0] c_rx_last   = 24'(rx_timeout - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_rdat;
    logic [23:0] r_idle_cnt;
    logic [15:0] r_bus_cnt;
    logic        r_nak;
    logic        r_gap;
    logic        w_term;
    logic        w_fail;
    logic        w_in_bus;

    assign w_in_bus = (r_state == S_BUS);
    assign wb_cyc_o = w_in_bus;
    assign wb_stb_o = w_in_bus;
    assign wb_we_o  = w_in_bus & r_we;
    assign wb_sel_o = w_in_bus ? 4'hF : 4'h0;
    assign wb_adr_o = w_in_bus ? r_adr : 32'h0;
    assign wb_dat_o = w_in_bus ? r_dat : 32'h0;
    assign busy_o   = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_term      = 1'b0;
        w_fail      = 1'b0;
        tx_stb      = 1'b0;
        tx_data     = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (rx_stb && (rx_data == c_cmd_write || rx_data == c_cmd_read))
                    w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (rx_stb) begin
                    if (r_cnt == 2'd3)
                        w_state_nxt = r_we ? S_DATA : S_BUS;
                end else if (r_idle_cnt == c_rx_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_stb) begin
                    if (r_cnt == 2'd3)
                        w_state_nxt = S_BUS;
                end else if (r_idle_cnt == c_rx_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUS: begin
                // err/rty outrank a simultaneous ack; a late ack still wins over the timeout
                if (wb_err_i || wb_rty_i) begin
                    w_term = 1'b1;
                    w_fail = 1'b1;
                end else if (wb_ack_i) begin
                    w_term = 1'b1;
                end else if (r_bus_cnt == c_bus_last) begin
                    w_term = 1'b1;
                    w_fail = 1'b1;
                end
                if (w_term)
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (r_nak)
                    tx_data = c_rsp_nak;
                else if (r_we)
                    tx_data = c_rsp_ack;
                else begin
                    case (r_cnt)
                        2'd0:    tx_data = r_rdat[31:24];
                        2'd1:    tx_data = r_rdat[23:16];
                        2'd2:    tx_data = r_rdat[15:8];
                        default: tx_data = r_rdat[7:0];
                    endcase
                end
                // r_gap forces a dead cycle between strobes
                if (!tx_busy && !r_gap) begin
                    tx_stb = 1'b1;
                    if (r_nak || r_we || r_cnt == 2'd3)
                        w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_we       <= 1'b0;
            r_adr      <= 32'h0;
            r_dat      <= 32'h0;
            r_rdat     <= 32'h0;
            r_idle_cnt <= 24'd0;
            r_bus_cnt  <= 16'd0;
            r_nak      <= 1'b0;
            r_gap      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= tx_stb;
            case (r_state)
                S_IDLE: begin
                    r_cnt      <= 2'd0;
                    r_idle_cnt <= 24'd0;
                    r_bus_cnt  <= 16'd0;
                    if (w_state_nxt == S_ADDR) begin
                        r_we  <= (rx_data == c_cmd_write);
                        r_dat <= 32'h0;
                        r_nak <= 1'b0;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (rx_stb) begin
                        r_cnt      <= r_cnt + 2'd1;
                        r_idle_cnt <= 24'd0;
                        if (r_state == S_ADDR)
                            r_adr <= {r_adr[23:0], rx_data};
                        else
                            r_dat <= {r_dat[23:0], rx_data};
                    end else if (w_state_nxt == S_IDLE) begin
                        r_cnt      <= 2'd0;
                        r_idle_cnt <= 24'd0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 24'd1;
                    end
                end
                S_BUS: begin
                    if (w_term) begin
                        r_bus_cnt <= 16'd0;
                        r_nak     <= w_fail;
                        if (!w_fail)
                            r_rdat <= wb_dat_i;
                    end else begin
                        r_bus_cnt <= r_bus_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (tx_stb)
                        r_cnt <= (w_state_nxt == S_IDLE) ? 2'd0 : r_cnt + 2'd1;
                end
                default: r_cnt <= 2'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_dbg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_dbg_master
// Brief    : Directed self-checking bench for wb_dbg_master.
// Revision : 1.0
// ============================================================================
module tb_wb_dbg_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_stb = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_stb;
    logic        tx_busy = 1'b0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_dbg_master #(
        .bus_timeout(16),
        .rx_timeout (50)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rx_data (rx_data),
        .rx_stb  (rx_stb),
        .tx_data (tx_data),
        .tx_stb  (tx_stb),
        .tx_busy (tx_busy),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o),
        .wb_we_o (wb_we_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i),
        .busy_o  (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bytes go out MSB first with one idle cycle between them.
    task automatic send_frame(input logic [71:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            rx_data = frame[8*(n-1-i) +: 8];
            rx_stb  = 1'b1;
            tick();
            rx_stb  = 1'b0;
            if (i != n - 1)
                tick();
        end
    endtask

    int          n_hi;
    logic        seen;
    logic [31:0] rd_word;

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_cyc",    {31'h0, wb_cyc_o}, 32'h0);
        check("rst_stb",    {31'h0, wb_stb_o}, 32'h0);
        check("rst_we",     {31'h0, wb_we_o},  32'h0);
        check("rst_sel",    {28'h0, wb_sel_o}, 32'h0);
        check("rst_adr",    wb_adr_o,          32'h0);
        check("rst_dat",    wb_dat_o,          32'h0);
        check("rst_txstb",  {31'h0, tx_stb},   32'h0);
        check("rst_txdata", {24'h0, tx_data},  32'h0);
        check("rst_busy",   {31'h0, busy_o},   32'h0);
        rst_i = 1'b0;
        tick();

        // ---------------- write, ack after 3 cycles ----------------
        send_frame(72'h01_00000010_DEADBEEF, 9);
        check("wr_cyc",  {31'h0, wb_cyc_o}, 32'h1);
        check("wr_stb",  {31'h0, wb_stb_o}, 32'h1);
        check("wr_we",   {31'h0, wb_we_o},  32'h1);
        check("wr_sel",  {28'h0, wb_sel_o}, 32'hF);
        check("wr_adr",  wb_adr_o,          32'h0000_0010);
        check("wr_dat",  wb_dat_o,          32'hDEAD_BEEF);
        check("wr_busy", {31'h0, busy_o},   32'h1);
        tick();
        tick();
        wb_ack_i = 1'b1;
        check("wr_ack_cyc", {31'h0, wb_cyc_o}, 32'h1);
        check("wr_ack_adr", wb_adr_o,          32'h0000_0010);
        tick();
        wb_ack_i = 1'b0;
        check("wr_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);
        check("wr_txstb",    {31'h0, tx_stb},   32'h1);
        check("wr_txdata",   {24'h0, tx_data},  32'h06);
        tick();
        check("wr_idle",     {31'h0, busy_o},   32'h0);
        check("wr_txstb_end",{31'h0, tx_stb},   32'h0);

        // ---------------- read, 12345678, tx_busy gating ----------------
        send_frame(72'h02_F0000004, 5);
        check("rd_cyc", {31'h0, wb_cyc_o}, 32'h1);
        check("rd_we",  {31'h0, wb_we_o},  32'h0);
        check("rd_adr", wb_adr_o,          32'hF000_0004);
        wb_dat_i = 32'h1234_5678;
        wb_ack_i = 1'b1;
        tx_busy  = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        check("rd_cyc_drop",  {31'h0, wb_cyc_o}, 32'h0);
        check("rd_hold_busy0",{31'h0, tx_stb},   32'h0);
        tick();
        check("rd_hold_busy1",{31'h0, tx_stb},   32'h0);
        tx_busy = 1'b0;
        #1;
        check("rd_b0_stb",  {31'h0, tx_stb},  32'h1);
        check("rd_b0_data", {24'h0, tx_data}, 32'h12);
        tick();
        tx_busy = 1'b1;
        #1;
        check("rd_b1_wait", {31'h0, tx_stb},  32'h0);
        tick();
        tx_busy = 1'b0;
        #1;
        check("rd_b1_stb",  {31'h0, tx_stb},  32'h1);
        check("rd_b1_data", {24'h0, tx_data}, 32'h34);
        tick();
        check("rd_gap1",    {31'h0, tx_stb},  32'h0);
        tick();
        check("rd_b2_stb",  {31'h0, tx_stb},  32'h1);
        check("rd_b2_data", {24'h0, tx_data}, 32'h56);
        tick();
        check("rd_gap2",    {31'h0, tx_stb},  32'h0);
        tick();
        check("rd_b3_stb",  {31'h0, tx_stb},  32'h1);
        check("rd_b3_data", {24'h0, tx_data}, 32'h78);
        tick();
        check("rd_idle",    {31'h0, busy_o},  32'h0);
        check("rd_end_stb", {31'h0, tx_stb},  32'h0);

        // ---------------- read timeout, bus_timeout = 16 ----------------
        send_frame(72'h02_00000020, 5);
        n_hi = 0;
        while (wb_cyc_o && wb_stb_o && n_hi < 40) begin
            n_hi++;
            tick();
        end
        check("to_cycles", n_hi,                16);
        check("to_txstb",  {31'h0, tx_stb},    32'h1);
        check("to_txdata", {24'h0, tx_data},   32'h15);
        tick();
        check("to_idle",   {31'h0, busy_o},    32'h0);

        // ---------------- ack and err together -> NAK ----------------
        send_frame(72'h01_00000030_11223344, 9);
        check("ae_cyc", {31'h0, wb_cyc_o}, 32'h1);
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        check("ae_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);
        check("ae_txstb",    {31'h0, tx_stb},   32'h1);
        check("ae_txdata",   {24'h0, tx_data},  32'h15);
        tick();
        check("ae_idle",     {31'h0, busy_o},   32'h0);

        // ---------------- bogus command byte ----------------
        send_frame(72'h7F, 1);
        check("bad_busy", {31'h0, busy_o},   32'h0);
        tick();
        check("bad_cyc",  {31'h0, wb_cyc_o}, 32'h0);
        check("bad_tx",   {31'h0, tx_stb},   32'h0);

        // ---------------- partial frame, rx_timeout = 50 ----------------
        send_frame(72'h01_0000, 3);
        check("pf_busy_start", {31'h0, busy_o}, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 49; i++) begin
            tick();
            seen = seen | wb_cyc_o | tx_stb;
        end
        check("pf_busy_edge",  {31'h0, busy_o}, 32'h1);
        tick();
        check("pf_idle",       {31'h0, busy_o}, 32'h0);
        check("pf_no_activity",{31'h0, seen},   32'h0);

        // ---------------- resync read; stray rx byte during BUS ----------------
        send_frame(72'h02_00000040, 5);
        check("rs_adr", wb_adr_o, 32'h0000_0040);
        rx_data = 8'h02;
        rx_stb  = 1'b1;
        tick();
        rx_stb   = 1'b0;
        wb_dat_i = 32'hA5A5_0001;
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        rd_word  = 32'h0;
        n_hi     = 0;
        for (int i = 0; i < 12 && n_hi < 4; i++) begin
            if (tx_stb) begin
                rd_word = {rd_word[23:0], tx_data};
                n_hi++;
            end
            tick();
        end
        check("rs_nbytes", n_hi,    4);
        check("rs_data",   rd_word, 32'hA5A5_0001);
        check("rs_idle",   {31'h0, busy_o}, 32'h0);

        // ---------------- reset mid-BUS ----------------
        send_frame(72'h02_00000050, 5);
        check("mr_stb_pre", {31'h0, wb_stb_o}, 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        check("mr_cyc_async", {31'h0, wb_cyc_o}, 32'h0);
        check("mr_stb_async", {31'h0, wb_stb_o}, 32'h0);
        check("mr_busy",      {31'h0, busy_o},   32'h0);
        check("mr_adr",       wb_adr_o,          32'h0);
        tick();
        rst_i = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | tx_stb | wb_cyc_o;
        end
        check("mr_no_resp", {31'h0, seen},   32'h0);
        check("mr_idle",    {31'h0, busy_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
